// File: rtl/outport_capture_fifo.sv
// Change-detecting capture FIFO on the processor outPort, drained over valid/ready.
// Define OUTCAP_TIMESTAMP_EN to store a free-running cycle stamp beside each entry.
module outport_capture_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          inData,
  input  logic                       capEn,
  output logic [DATA_W-1:0]          outData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clrOvf
`ifdef OUTCAP_TIMESTAMP_EN
  ,
  output logic [STAMP_W-1:0]         outStamp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] prev_q, prev_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic empty, is_full, chg, pop, push;

`ifdef OUTCAP_TIMESTAMP_EN
  logic [STAMP_W-1:0] stamp_cnt_q, stamp_cnt_d;
  logic [STAMP_W-1:0] stamp_mem_q [DEPTH];
  logic [STAMP_W-1:0] stamp_mem_d [DEPTH];
`endif

  always_comb begin
    empty   = (wptr_q == rptr_q);
    is_full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    chg     = capEn && (inData != prev_q);
    pop     = !empty && outReady;
    // A full FIFO still accepts a change when the head leaves in the same cycle.
    push    = chg && (!is_full || pop);

    prev_d  = inData;
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as clrOvf keeps the flag set.
    ovf_d = ovf_q;
    if (chg && is_full && !pop) ovf_d = 1'b1;
    else if (clrOvf)            ovf_d = 1'b0;

    mem_d = mem_q;
    if (push) mem_d[wptr_q[AW-1:0]] = inData;

`ifdef OUTCAP_TIMESTAMP_EN
    stamp_cnt_d = stamp_cnt_q + STAMP_W'(1);
    stamp_mem_d = stamp_mem_q;
    if (push) stamp_mem_d[wptr_q[AW-1:0]] = stamp_cnt_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      prev_q  <= prev_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef OUTCAP_TIMESTAMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stamp_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stamp_mem_q[i] <= '0;
    end else begin
      stamp_cnt_q <= stamp_cnt_d;
      for (int i = 0; i < DEPTH; i++) stamp_mem_q[i] <= stamp_mem_d[i];
    end
  end

  assign outStamp = stamp_mem_q[rptr_q[AW-1:0]];
`endif

  assign outData  = mem_q[rptr_q[AW-1:0]];
  assign outValid = !empty;
  assign count    = count_q;
  assign full     = is_full;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_outport_capture_fifo.sv
// Directed self-checking bench for outport_capture_fifo (DEPTH=8).
// The stamp scenario runs only when OUTCAP_TIMESTAMP_EN is defined.
module tb_outport_capture_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
`ifdef OUTCAP_TIMESTAMP_EN
  localparam int STAMP_W = 4;
`else
  localparam int STAMP_W = 16;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] inData;
  logic              capEn;
  logic [DATA_W-1:0] outData;
  logic              outValid;
  logic              outReady;
  logic [3:0]        count;
  logic              full;
  logic              overflow;
  logic              clrOvf;
`ifdef OUTCAP_TIMESTAMP_EN
  logic [STAMP_W-1:0] outStamp;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  outport_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk(clk), .reset(reset), .inData(inData), .capEn(capEn),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .count(count), .full(full), .overflow(overflow), .clrOvf(clrOvf)
`ifdef OUTCAP_TIMESTAMP_EN
    , .outStamp(outStamp)
`endif
  );

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; inData = '0; capEn = 1'b1; outReady = 1'b0; clrOvf = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0b exp 0", outValid); end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL rst_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL rst_full got %0b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf got %0b exp 0", overflow); end
    checks++; if (outData !== 8'd0) begin errors++; $display("[TB] FAIL rst_data got %0d exp 0", outData); end
  endtask

  task automatic test_latency();
    do_reset();
    step();
    inData = 8'd5;
    #2;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL lat_early_valid got %0b exp 0", outValid); end
    step();
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL lat_valid got %0b exp 1", outValid); end
    checks++; if (outData !== 8'd5) begin errors++; $display("[TB] FAIL lat_data got %0d exp 5", outData); end
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL lat_count got %0d exp 1", count); end
    step();
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL lat_hold_count got %0d exp 1", count); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int v = 1; v <= 10; v++) begin
      inData = 8'(v);
      step();
      if (v == 7) begin
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL fill7_full got %0b exp 0", full); end
      end
      if (v == 8) begin
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill8_full got %0b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill8_ovf got %0b exp 0", overflow); end
      end
      if (v == 9) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL fill9_ovf got %0b exp 1", overflow); end
      end
    end
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL fill_count got %0d exp 8", count); end
    checks++; if (outData !== 8'd1) begin errors++; $display("[TB] FAIL fill_head got %0d exp 1", outData); end
    clrOvf = 1'b1;
    step();
    clrOvf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf got %0b exp 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tail [8];
    exp_tail = '{8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inData = 8'(11 + i);
      step();
      checks++; if (outData !== 8'(i + 2)) begin errors++; $display("[TB] FAIL b2b_head%0d got %0d exp %0d", i, outData, i + 2); end
      checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL b2b_count%0d got %0d exp 8", i, count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf%0d got %0b exp 0", i, overflow); end
    end
    for (int j = 0; j < 8; j++) begin
      checks++; if (outData !== exp_tail[j]) begin errors++; $display("[TB] FAIL drain%0d got %0d exp %0d", j, outData, exp_tail[j]); end
      step();
    end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL drain_count got %0d exp 0", count); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid got %0b exp 0", outValid); end
    outReady = 1'b0;
  endtask

  task automatic test_cap_disable();
    do_reset();
    capEn = 1'b0;
    inData = 8'd3;
    step();
    inData = 8'd7;
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL capdis_count got %0d exp 0", count); end
    capEn = 1'b1;
    step();
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL capen_count got %0d exp 0", count); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL capen_valid got %0b exp 0", outValid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      inData = 8'(v);
      step();
    end
    checks++; if (count !== 4'd4) begin errors++; $display("[TB] FAIL pre_rst_count got %0d exp 4", count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid got %0b exp 0", outValid); end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL arst_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL arst_ovf got %0b exp 0", overflow); end
    inData = 8'd0;
    step();
    reset = 1'b0;
    step();
    inData = 8'd9;
    step();
    step();
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL post_rst_count got %0d exp 1", count); end
    checks++; if (outData !== 8'd9) begin errors++; $display("[TB] FAIL post_rst_data got %0d exp 9", outData); end
  endtask

`ifdef OUTCAP_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    for (int i = 0; i < 14; i++) step();
    inData = 8'd1;
    step();
    step();
    step();
    inData = 8'd2;
    step();
    checks++; if (outStamp !== 4'd14) begin errors++; $display("[TB] FAIL stamp_first got %0d exp 14", outStamp); end
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    checks++; if (outStamp !== 4'd1) begin errors++; $display("[TB] FAIL stamp_second got %0d exp 1", outStamp); end
    checks++; if (outData !== 8'd2) begin errors++; $display("[TB] FAIL stamp_data got %0d exp 2", outData); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill_overflow();
    test_back_to_back();
    test_cap_disable();
    test_async_reset();
`ifdef OUTCAP_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
